// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin share of one external combinational ALU by two requesters.
// Ports: clk/rst_n, req0_*/req1_* operand channels, rsp0_*/rsp1_* result channels, alu_* operand/result, busy.
module alu_share_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_src1,
   input  logic [31:0] req0_src2,
   input  logic [31:0] req0_imm_val,
   input  logic        req0_imm,
   input  logic [2:0]  req0_funct3,
   input  logic [6:0]  req0_funct7,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_src1,
   input  logic [31:0] req1_src2,
   input  logic [31:0] req1_imm_val,
   input  logic        req1_imm,
   input  logic [2:0]  req1_funct3,
   input  logic [6:0]  req1_funct7,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_res,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_res,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic [31:0] alu_imm_val,
   output logic        alu_imm,
   output logic [2:0]  alu_funct3,
   output logic [6:0]  alu_funct7,
   input  logic [31:0] alu_res,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        owner_q;
   logic        last_q;
   logic [31:0] res_q;
   logic        grant0;
   logic        grant1;
   logic        accept;
   logic        rsp_hs;

   // last_q names the requester served most recently; on a tie the other one wins
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      unique case (1'b1)
         (req0_valid & req1_valid): begin
            grant0 = last_q;
            grant1 = ~last_q;
         end
         (req0_valid & ~req1_valid): grant0 = 1'b1;
         (~req0_valid & req1_valid): grant1 = 1'b1;
         default: ;
      endcase
   end

   assign req0_ready = (state_q == IDLE) & grant0;
   assign req1_ready = (state_q == IDLE) & grant1;
   assign accept     = req0_ready | req1_ready;

   assign rsp0_valid = (state_q == RESP) & ~owner_q;
   assign rsp1_valid = (state_q == RESP) & owner_q;
   assign rsp0_res   = res_q;
   assign rsp1_res   = res_q;
   assign rsp_hs     = (rsp0_valid & rsp0_ready)
                     | (rsp1_valid & rsp1_ready);

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: state_d = RESP;
         RESP: if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // operand register feeds the ALU directly; it only moves on an accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_src1    <= '0;
         alu_src2    <= '0;
         alu_imm_val <= '0;
         alu_imm     <= 1'b0;
         alu_funct3  <= '0;
         alu_funct7  <= '0;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
      end else if (accept) begin
         alu_src1    <= grant1 ? req1_src1    : req0_src1;
         alu_src2    <= grant1 ? req1_src2    : req0_src2;
         alu_imm_val <= grant1 ? req1_imm_val : req0_imm_val;
         alu_imm     <= grant1 ? req1_imm     : req0_imm;
         alu_funct3  <= grant1 ? req1_funct3  : req0_funct3;
         alu_funct7  <= grant1 ? req1_funct7  : req0_funct7;
         owner_q     <= grant1;
         last_q      <= grant1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else if (state_q == EXEC) begin
         res_q <= alu_res;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: scoreboard bench for alu_share_ctrl.
// A behavioural RV32 ALU is attached to the alu_* ports.
module tb_alu_share_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_imm;
   logic [31:0] req0_src1, req0_src2, req0_imm_val;
   logic [2:0]  req0_funct3;
   logic [6:0]  req0_funct7;
   logic        req1_valid, req1_ready, req1_imm;
   logic [31:0] req1_src1, req1_src2, req1_imm_val;
   logic [2:0]  req1_funct3;
   logic [6:0]  req1_funct7;
   logic        rsp0_valid, rsp0_ready;
   logic [31:0] rsp0_res;
   logic        rsp1_valid, rsp1_ready;
   logic [31:0] rsp1_res;
   logic [31:0] alu_src1, alu_src2, alu_imm_val, alu_res;
   logic        alu_imm;
   logic [2:0]  alu_funct3;
   logic [6:0]  alu_funct7;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      bit          own;
      logic [31:0] res;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu_share_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_src1(req0_src1), .req0_src2(req0_src2),
      .req0_imm_val(req0_imm_val), .req0_imm(req0_imm),
      .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_src1(req1_src1), .req1_src2(req1_src2),
      .req1_imm_val(req1_imm_val), .req1_imm(req1_imm),
      .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_res(rsp0_res),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_res(rsp1_res),
      .alu_src1(alu_src1), .alu_src2(alu_src2),
      .alu_imm_val(alu_imm_val), .alu_imm(alu_imm),
      .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
      .alu_res(alu_res), .busy(busy)
   );

   function automatic logic [31:0] alu_f(
      input logic [31:0] a,
      input logic [31:0] b2,
      input logic [31:0] iv,
      input logic        imm,
      input logic [2:0]  f3,
      input logic [6:0]  f7
   );
      logic [31:0] b;
      b = imm ? iv : b2;
      case (f3)
         3'd0: alu_f = (f7[5] && !imm) ? a - b : a + b;
         3'd1: alu_f = a << b[4:0];
         3'd2: alu_f = {31'd0, $signed(a) < $signed(b)};
         3'd3: alu_f = {31'd0, a < b};
         3'd4: alu_f = a ^ b;
         3'd5: alu_f = f7[5] ? $unsigned($signed(a) >>> b[4:0])
                             : a >> b[4:0];
         3'd6: alu_f = a | b;
         default: alu_f = a & b;
      endcase
   endfunction

   always_comb alu_res = alu_f(alu_src1, alu_src2, alu_imm_val,
                               alu_imm, alu_funct3, alu_funct7);

   task automatic set0(input logic [31:0] s1, s2, iv,
                       input logic im, input logic [2:0] f3,
                       input logic [6:0] f7);
      req0_src1 = s1; req0_src2 = s2; req0_imm_val = iv;
      req0_imm = im; req0_funct3 = f3; req0_funct7 = f7;
      req0_valid = 1'b1;
   endtask

   task automatic set1(input logic [31:0] s1, s2, iv,
                       input logic im, input logic [2:0] f3,
                       input logic [6:0] f7);
      req1_src1 = s1; req1_src2 = s2; req1_imm_val = iv;
      req1_imm = im; req1_funct3 = f3; req1_funct7 = f7;
      req1_valid = 1'b1;
   endtask

   task automatic push(input bit own, input logic [31:0] res);
      exp_t e;
      e.own = own;
      e.res = res;
      sb.push_back(e);
   endtask

   // advance to the next falling edge; a requester drops valid once accepted
   task automatic tick();
      logic a0, a1;
      a0 = req0_ready;
      a1 = req1_ready;
      @(negedge clk);
      cyc++;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      #1;
   endtask

   task automatic wait_rsp(input int budget, output bit ok,
                           output bit own, output logic [31:0] res);
      ok = 1'b0; own = 1'b0; res = '0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (rsp0_valid || rsp1_valid) begin
            ok  = 1'b1;
            own = rsp1_valid;
            res = rsp1_valid ? rsp1_res : rsp0_res;
         end
      end
   endtask

   task automatic rand_op(input bit who);
      logic [31:0] s1, s2, iv;
      logic        im;
      logic [2:0]  f3;
      logic [6:0]  f7;
      s1 = $urandom; s2 = $urandom; iv = $urandom;
      im = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (who) set1(s1, s2, iv, im, f3, f7);
      else     set0(s1, s2, iv, im, f3, f7);
      push(who, alu_f(s1, s2, iv, im, f3, f7));
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b%b exp 00", req0_ready, req1_ready); end
      n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL rst_rspv got %b%b exp 00", rsp0_valid, rsp1_valid); end
      n_cmp++; if ({alu_src1, alu_src2, alu_imm_val} !== 96'd0) begin n_err++; $display("FAIL rst_alu_ops got %h %h %h exp 0", alu_src1, alu_src2, alu_imm_val); end
      n_cmp++; if ({alu_imm, alu_funct3, alu_funct7} !== 11'd0) begin n_err++; $display("FAIL rst_alu_ctl got %b %h %h exp 0", alu_imm, alu_funct3, alu_funct7); end
      n_cmp++; if (rsp0_res !== 32'd0) begin n_err++; $display("FAIL rst_res got %h exp 0", rsp0_res); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_add();
      exp_t e;
      set0(32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 7'h00);
      push(1'b0, 32'd12);
      #1;
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL add_ready got %b%b exp 10", req0_ready, req1_ready); end
      tick();
      n_cmp++; if (busy !== 1'b1 || req0_ready !== 1'b0) begin n_err++; $display("FAIL add_exec busy/ready got %b%b exp 10", busy, req0_ready); end
      n_cmp++; if (alu_src1 !== 32'd5 || alu_src2 !== 32'd7) begin n_err++; $display("FAIL add_ops got %h %h exp 5 7", alu_src1, alu_src2); end
      n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_early_rsp got %b exp 0", rsp0_valid); end
      tick();
      e = sb.pop_front();
      n_cmp++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_res !== e.res) begin n_err++; $display("FAIL add_rsp got v%b%b res %h exp v10 res %h", rsp0_valid, rsp1_valid, rsp0_res, e.res); end
      tick();
      n_cmp++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_done busy/rspv got %b%b exp 00", busy, rsp0_valid); end
   endtask

   task automatic test_tie();
      exp_t e;
      bit ok, own;
      logic [31:0] res;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set0(32'd10, 32'd3, 32'd0, 1'b0, 3'd0, 7'h20);
      set1(32'hF0, 32'h3C, 32'd0, 1'b0, 3'd4, 7'h00);
      push(1'b0, 32'd7);
      push(1'b1, 32'hCC);
      #1;
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL tie_grant got %b%b exp 10", req0_ready, req1_ready); end
      for (int k = 0; k < 2; k++) begin
         wait_rsp(10, ok, own, res);
         e = sb.pop_front();
         n_cmp++; if (!ok || own !== e.own || res !== e.res) begin n_err++; $display("FAIL tie_rsp%0d got ok%0d own%0d res %h exp own%0d res %h", k, ok, own, res, e.own, e.res); end
      end
      set0(32'd1, 32'd1, 32'd0, 1'b0, 3'd0, 7'h00);
      set1(32'hFF, 32'h0F, 32'd0, 1'b0, 3'd7, 7'h00);
      push(1'b0, 32'd2);
      push(1'b1, 32'h0F);
      for (int k = 0; k < 2; k++) begin
         wait_rsp(10, ok, own, res);
         e = sb.pop_front();
         n_cmp++; if (!ok || own !== e.own || res !== e.res) begin n_err++; $display("FAIL tie3_rsp%0d got ok%0d own%0d res %h exp own%0d res %h", k, ok, own, res, e.own, e.res); end
      end
      tick();
   endtask

   task automatic test_imm();
      exp_t e;
      bit ok, own;
      logic [31:0] res;
      set1(32'h1, 32'hFFFF, 32'h10, 1'b1, 3'd6, 7'h00);
      push(1'b1, 32'h11);
      #1;
      n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL imm_ready got %b exp 1", req1_ready); end
      tick();
      n_cmp++; if (alu_imm !== 1'b1 || alu_imm_val !== 32'h10 || alu_src2 !== 32'hFFFF) begin n_err++; $display("FAIL imm_ops got %b %h %h exp 1 10 ffff", alu_imm, alu_imm_val, alu_src2); end
      wait_rsp(10, ok, own, res);
      e = sb.pop_front();
      n_cmp++; if (!ok || own !== e.own || res !== e.res) begin n_err++; $display("FAIL imm_rsp got ok%0d own%0d res %h exp own%0d res %h", ok, own, res, e.own, e.res); end
      tick();
   endtask

   task automatic test_backpressure();
      exp_t e;
      bit ok, own;
      logic [31:0] res;
      rsp0_ready = 1'b0;
      set0(32'd3, 32'd4, 32'd0, 1'b0, 3'd0, 7'h00);
      set1(32'd1, 32'd2, 32'd0, 1'b0, 3'd6, 7'h00);
      push(1'b0, 32'd7);
      push(1'b1, 32'd3);
      #1;
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'd7 || req1_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d got v%b res %h r1rdy %b busy %b exp v1 res 7 r1rdy 0 busy 1", k, rsp0_valid, rsp0_res, req1_ready, busy); end
         tick();
      end
      rsp0_ready = 1'b1;
      e = sb.pop_front();
      n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_res !== e.res) begin n_err++; $display("FAIL bp_rsp got v%b res %h exp v1 res %h", rsp0_valid, rsp0_res, e.res); end
      tick();
      n_cmp++; if (req1_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_next got r1rdy %b busy %b exp 1 0", req1_ready, busy); end
      wait_rsp(10, ok, own, res);
      e = sb.pop_front();
      n_cmp++; if (!ok || own !== e.own || res !== e.res) begin n_err++; $display("FAIL bp_rsp1 got ok%0d own%0d res %h exp own%0d res %h", ok, own, res, e.own, e.res); end
      tick();
   endtask

   task automatic test_reset_exec();
      exp_t e;
      bit ok, own;
      logic [31:0] res;
      set0(32'd2, 32'd2, 32'd0, 1'b0, 3'd0, 7'h00);
      set1(32'd5, 32'd6, 32'd0, 1'b0, 3'd4, 7'h00);
      #1;
      tick();
      req1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL rx_state got busy %b v%b%b exp 0 00", busy, rsp0_valid, rsp1_valid); end
      n_cmp++; if (alu_src1 !== 32'd0 || alu_src2 !== 32'd0 || alu_funct3 !== 3'd0) begin n_err++; $display("FAIL rx_alu got %h %h %h exp 0", alu_src1, alu_src2, alu_funct3); end
      n_cmp++; if (rsp0_res !== 32'd0) begin n_err++; $display("FAIL rx_res got %h exp 0", rsp0_res); end
      tick();
      tick();
      n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL rx_norsp got %b%b exp 00", rsp0_valid, rsp1_valid); end
      rst_n = 1'b1;
      set0(32'd8, 32'd1, 32'd0, 1'b0, 3'd0, 7'h20);
      set1(32'h0F, 32'h1, 32'd0, 1'b0, 3'd1, 7'h00);
      push(1'b0, 32'd7);
      push(1'b1, 32'h1E);
      #1;
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL rx_grant got %b%b exp 10", req0_ready, req1_ready); end
      for (int k = 0; k < 2; k++) begin
         wait_rsp(10, ok, own, res);
         e = sb.pop_front();
         n_cmp++; if (!ok || own !== e.own || res !== e.res) begin n_err++; $display("FAIL rx_rsp%0d got ok%0d own%0d res %h exp own%0d res %h", k, ok, own, res, e.own, e.res); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int issued;
      int got;
      int last_cyc;
      bit last_own;
      logic a0, a1, rv0, rv1;
      logic [31:0] res;
      issued = 2;
      got = 0;
      last_cyc = -1;
      last_own = 1'b1;
      rand_op(1'b0);
      rand_op(1'b1);
      #1;
      for (int i = 0; i < 200 && got < 12; i++) begin
         a0 = req0_ready;
         a1 = req1_ready;
         if (a0 || a1) begin
            n_cmp++; if (a1 !== !last_own) begin n_err++; $display("FAIL tp_order got own%0d exp own%0d", a1, !last_own); end
            if (last_cyc >= 0) begin
               n_cmp++; if (cyc - last_cyc != 3) begin n_err++; $display("FAIL tp_spacing got %0d exp 3", cyc - last_cyc); end
            end
            last_own = a1;
            last_cyc = cyc;
         end
         tick();
         if (a0 && issued < 12) begin rand_op(1'b0); issued++; end
         if (a1 && issued < 12) begin rand_op(1'b1); issued++; end
         #1;
         rv0 = rsp0_valid;
         rv1 = rsp1_valid;
         if (rv0 || rv1) begin
            res = rv1 ? rsp1_res : rsp0_res;
            e = sb.pop_front();
            got++;
            n_cmp++; if (rv1 !== e.own || res !== e.res || (rv0 && rv1)) begin n_err++; $display("FAIL tp_rsp%0d got v%b%b res %h exp own%0d res %h", got, rv0, rv1, res, e.own, e.res); end
         end
      end
      n_cmp++; if (got != 12) begin n_err++; $display("FAIL tp_count got %0d exp 12", got); end
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_src1 = '0; req0_src2 = '0;
      req0_imm_val = '0; req0_imm = 1'b0;
      req0_funct3 = '0; req0_funct7 = '0;
      req1_valid = 1'b0; req1_src1 = '0; req1_src2 = '0;
      req1_imm_val = '0; req1_imm = 1'b0;
      req1_funct3 = '0; req1_funct7 = '0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      test_reset();
      test_single_add();
      test_tie();
      test_imm();
      test_backpressure();
      test_reset_exec();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
